// File: rtl/types_pkg.sv
// Shared decode-stage types: opcodes, stall causes and the forwarding-select width helper.
package types_pkg;

    typedef enum logic [3:0] {
        NOP, ARITHM, LW, SW, BE, BLT, BGT, JMP, MULDIV
    } opcode_t;

    typedef enum logic [1:0] {
        SC_NONE, SC_LOAD_USE, SC_R0_BUSY, SC_MULDIV_BUSY
    } stall_cause_t;

    // Select code 0 is the register file, 1..depth name a tracked slot.
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic is_writer(input opcode_t op);
        return (op == ARITHM) || (op == LW);
    endfunction

    function automatic logic is_src_reader(input opcode_t op);
        return (op == ARITHM) || (op == SW) || (op == BE) || (op == BLT) || (op == BGT);
    endfunction

    function automatic logic is_r0_reader(input opcode_t op);
        return (op == BE) || (op == BLT) || (op == BGT);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_slot.sv
// One in-flight producer slot: registers {valid, dst, is_load} and compares dst against each source.
module hazard_track_slot #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_vld,
    input  logic [REG_AW-1:0]                in_dst,
    input  logic                             in_ld,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]   cmp_addr,
    output logic                             out_vld,
    output logic [REG_AW-1:0]                out_dst,
    output logic                             out_ld,
    output logic [NUM_SRC-1:0]               hit
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dst <= '0;
            out_ld  <= 1'b0;
        end else begin
            out_vld <= in_vld;
            out_dst <= in_dst;
            out_ld  <= in_ld;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SRC; i++)
            hit[i] = out_vld && (out_dst == cmp_addr[i]);
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage forwarding/stall unit with an internal producer shift register and MUL/DIV R0 tracker.
// Optional HAZARD_STATS_EN builds saturating stall/forward statistics counters.
module hazard_scoreboard_unit
    import types_pkg::*;
#(
    parameter  int REG_AW     = 4,
    parameter  int DEPTH      = 2,
    parameter  int NUM_SRC    = 2,
    parameter  int MULDIV_LAT = 4,
    localparam int FSW        = fwd_sel_w(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            id_valid,
    input  opcode_t                         id_opcode,
    input  logic                            id_r0_wr,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]  id_src,
    input  logic [REG_AW-1:0]               id_dst,
    input  logic                            flush,
    output logic [NUM_SRC-1:0][FSW-1:0]     fwd_sel,
    output logic [FSW-1:0]                  fwd_r0_sel,
    output logic                            stall,
    output logic [1:0]                      stall_cause,
    output logic [15:0]                     stat_stall_cnt,
    output logic [15:0]                     stat_fwd_cnt
);

    localparam int CW = $clog2(MULDIV_LAT + 1);

    // Index 0 is the entry offered by ID; index k is the output of slot k.
    logic [DEPTH:0]                  s_vld;
    logic [DEPTH:0]                  s_ld;
    logic [DEPTH:0][REG_AW-1:0]      s_dst;
    logic [DEPTH-1:0][NUM_SRC-1:0]   s_hit;
    logic                            unused_tail;

    logic [NUM_SRC-1:0][FSW-1:0]     pick;
    logic [NUM_SRC-1:0]              lu_vec;
    logic [CW-1:0]                   r0_cnt;
    logic [FSW-1:0]                  r0_age;
    logic                            r0_busy;
    logic                            src_rd, r0_rd;
    logic                            live, active, accept;
    logic                            c_lu, c_r0, c_md;

    assign src_rd  = is_src_reader(id_opcode);
    assign r0_rd   = is_r0_reader(id_opcode);
    assign r0_busy = (r0_cnt != '0);
    assign live    = id_valid & ~rst;
    assign active  = live & ~flush;
    assign accept  = active & ~stall;

    assign s_vld[0] = accept & is_writer(id_opcode);
    assign s_dst[0] = id_dst;
    assign s_ld[0]  = (id_opcode == LW);
    assign unused_tail = ^{s_dst, s_ld};

    for (genvar g = 1; g <= DEPTH; g++) begin : g_slot
        hazard_track_slot #(
            .REG_AW  (REG_AW),
            .NUM_SRC (NUM_SRC)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (s_vld[g-1]),
            .in_dst   (s_dst[g-1]),
            .in_ld    (s_ld[g-1]),
            .cmp_addr (id_src),
            .out_vld  (s_vld[g]),
            .out_dst  (s_dst[g]),
            .out_ld   (s_ld[g]),
            .hit      (s_hit[g-1])
        );
    end

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        pick   = '0;
        lu_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH; k >= 1; k--)
                if (s_hit[k-1][i]) pick[i] = FSW'(k);
            lu_vec[i] = src_rd & s_hit[0][i] & s_ld[1];
        end
    end

    always_comb begin
        c_lu  = active & (|lu_vec);
        c_r0  = active & r0_rd & r0_busy;
        c_md  = active & id_r0_wr & r0_busy;
        stall = c_lu | c_r0 | c_md;
        if (c_lu)      stall_cause = SC_LOAD_USE;
        else if (c_r0) stall_cause = SC_R0_BUSY;
        else if (c_md) stall_cause = SC_MULDIV_BUSY;
        else           stall_cause = SC_NONE;
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (live & src_rd & ~lu_vec[i]) fwd_sel[i] = pick[i];
        fwd_r0_sel = (live & r0_rd & ~r0_busy) ? r0_age : '0;
    end

    // r0_age counts cycles since R0 became forwardable; 0 means "use the register file".
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_cnt <= '0;
            r0_age <= '0;
        end else if (accept & id_r0_wr) begin
            r0_cnt <= CW'(MULDIV_LAT - 1);
            r0_age <= FSW'(MULDIV_LAT == 1 ? 1 : 0);
        end else begin
            if (r0_busy) r0_cnt <= r0_cnt - 1'b1;
            if (r0_cnt == CW'(1))
                r0_age <= FSW'(1);
            else if ((r0_age != '0) && (r0_age < FSW'(DEPTH)))
                r0_age <= r0_age + 1'b1;
            else
                r0_age <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic any_fwd;
    assign any_fwd = (|fwd_sel) | (|fwd_r0_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall && (stat_stall_cnt != 16'hFFFF))
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            if (accept && any_fwd && (stat_fwd_cnt != 16'hFFFF))
                stat_fwd_cnt <= stat_fwd_cnt + 16'd1;
        end
    end
`else
    assign stat_stall_cnt = 16'h0000;
    assign stat_fwd_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed vector bench for hazard_scoreboard_unit (DEPTH=2, MULDIV_LAT=4).
module tb_hazard_scoreboard_unit;
    import types_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid;
    opcode_t              id_opcode;
    logic                 id_r0_wr;
    logic [1:0][3:0]      id_src;
    logic [3:0]           id_dst;
    logic                 flush;
    logic [1:0][1:0]      fwd_sel;
    logic [1:0]           fwd_r0_sel;
    logic                 stall;
    logic [1:0]           stall_cause;
    logic [15:0]          stat_stall_cnt;
    logic [15:0]          stat_fwd_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(
        .REG_AW(4), .DEPTH(2), .NUM_SRC(2), .MULDIV_LAT(4)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_r0_wr(id_r0_wr), .id_src(id_src), .id_dst(id_dst), .flush(flush),
        .fwd_sel(fwd_sel), .fwd_r0_sel(fwd_r0_sel), .stall(stall),
        .stall_cause(stall_cause), .stat_stall_cnt(stat_stall_cnt),
        .stat_fwd_cnt(stat_fwd_cnt)
    );

    typedef struct {
        logic       vld;
        opcode_t    op;
        logic       r0w;
        logic [3:0] s0, s1, dst;
        logic       fl;
        logic [1:0] e_f0, e_f1, e_r0;
        logic       e_st;
        logic [1:0] e_c;
    } vec_t;

    function automatic vec_t mk(logic vld, opcode_t op, logic r0w, logic [3:0] s0, s1, dst,
                                logic fl, logic [1:0] f0, f1, r0, logic st, logic [1:0] c);
        vec_t v;
        v.vld = vld; v.op = op; v.r0w = r0w; v.s0 = s0; v.s1 = s1; v.dst = dst; v.fl = fl;
        v.e_f0 = f0; v.e_f1 = f1; v.e_r0 = r0; v.e_st = st; v.e_c = c;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.vld; id_opcode = v.op; id_r0_wr = v.r0w;
        id_src[0] = v.s0; id_src[1] = v.s1; id_dst = v.dst; flush = v.fl;
    endtask

    task automatic check(input string name, input vec_t v);
        n_vec++;
        if (fwd_sel[0] !== v.e_f0 || fwd_sel[1] !== v.e_f1 || fwd_r0_sel !== v.e_r0 ||
            stall !== v.e_st || stall_cause !== v.e_c) begin
            n_bad++;
            $display("FAIL %s: got f0=%0d f1=%0d r0=%0d stall=%0d cause=%0d, want f0=%0d f1=%0d r0=%0d stall=%0d cause=%0d",
                     name, fwd_sel[0], fwd_sel[1], fwd_r0_sel, stall, stall_cause,
                     v.e_f0, v.e_f1, v.e_r0, v.e_st, v.e_c);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input string name, input vec_t v);
        drive(v);
        @(negedge clk);
        check(name, v);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string name);
        rst = 1'b1;
        drive(mk(1, BE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check(name, mk(1, BE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mk(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t tbl[$];
    vec_t zero_be;

    initial begin
        rst = 1'b1;
        drive(mk(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        //                 vld op      r0w s0 s1 dst fl  f0 f1 r0 st c
        tbl.push_back(mk(1, ARITHM, 0, 1, 2, 3, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ARITHM, 0, 3, 4, 7, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, ARITHM, 0, 3, 7, 8, 0,  2, 1, 0, 0, 0));
        tbl.push_back(mk(0, NOP,    0, 8, 8, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW,     0, 1, 0, 5, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SW,     0, 9, 5, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, SW,     0, 9, 5, 0, 0,  0, 2, 0, 0, 0));
        tbl.push_back(mk(1, ARITHM, 0, 0, 0, 2, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ARITHM, 0, 0, 0, 2, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BLT,    0, 2, 2, 0, 0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(1, BGT,    0, 2, 1, 0, 0,  2, 0, 0, 0, 0));
        tbl.push_back(mk(1, MULDIV, 1, 1, 2, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BE,     0, 0, 0, 0, 0,  0, 0, 0, 1, 2));
        tbl.push_back(mk(1, BE,     0, 0, 0, 0, 0,  0, 0, 0, 1, 2));
        tbl.push_back(mk(1, BE,     0, 0, 0, 0, 0,  0, 0, 0, 1, 2));
        tbl.push_back(mk(1, BE,     0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
        tbl.push_back(mk(1, BE,     0, 0, 0, 0, 0,  0, 0, 2, 0, 0));
        tbl.push_back(mk(1, BE,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, MULDIV, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, MULDIV, 1, 0, 0, 0, 0,  0, 0, 0, 1, 3));
        tbl.push_back(mk(1, LW,     0, 0, 0, 6, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BE,     0, 6, 0, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, BE,     0, 6, 0, 0, 0,  2, 0, 1, 0, 0));
        tbl.push_back(mk(1, MULDIV, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BE,     1, 0, 0, 0, 0,  0, 0, 0, 1, 2));
        tbl.push_back(mk(1, LW,     0, 0, 0, 5, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ARITHM, 0, 9, 5, 9, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ARITHM, 0, 9, 5, 1, 0,  0, 2, 0, 0, 0));

        reset_check("reset_outputs");
        check16("reset_stat_stall", stat_stall_cnt, 16'h0000);
        check16("reset_stat_fwd", stat_fwd_cnt, 16'h0000);

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Reset while MUL/DIV is busy must discard the busy state and the R0 age.
        zero_be = mk(1, BE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mul_issue", mk(1, MULDIV, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("invalid_while_busy", mk(0, BE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_check("reset_mid_mul");
        step("be_after_reset", zero_be);

`ifdef HAZARD_STATS_EN
        step("stats_seed", mk(1, ARITHM, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0));
        drive(mk(1, ARITHM, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0));
        repeat (70000) @(posedge clk);
        #1;
        check16("stat_fwd_saturate", stat_fwd_cnt, 16'hFFFF);
        check16("stat_stall_none", stat_stall_cnt, 16'h0000);
`else
        check16("stat_stall_off", stat_stall_cnt, 16'h0000);
        check16("stat_fwd_off", stat_fwd_cnt, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
